// File: rtl/id_wb_sched.sv
// Decode-side register scoreboard plus a round-robin arbiter that merges the
// ALU and load writeback streams onto the register file's single write port.
module id_wb_sched #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5,
    parameter int CNTW  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RADDR-1:0] id_rs1,
    input  logic [RADDR-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [RADDR-1:0] id_rd,
    input  logic             id_rd_we,
    output logic             id_stall,
    input  logic             alu_valid,
    input  logic [RADDR-1:0] alu_rd,
    input  logic [XLEN-1:0]  alu_data,
    output logic             alu_ready,
    input  logic             mem_valid,
    input  logic [RADDR-1:0] mem_rd,
    input  logic [XLEN-1:0]  mem_data,
    output logic             mem_ready,
    output logic [RADDR-1:0] reg_write,
    output logic [XLEN-1:0]  data_write,
    output logic             err_underflow
);
    localparam int NREG = 1 << RADDR;
    localparam logic [CNTW-1:0] CMAX = '1;

    logic [NREG-1:0][CNTW-1:0] cnt;
    logic [NREG-1:0]           inc;
    logic [NREG-1:0]           dec;
    logic                      last_mem;
    logic                      hazard1, hazard2, waw_full, issue;
    logic                      grant_alu, grant_mem, grant, underflow;
    logic [RADDR-1:0]          g_rd;
    logic [XLEN-1:0]           g_data;

    assign hazard1  = id_rs1_used && (id_rs1 != '0) && (cnt[id_rs1] != '0);
    assign hazard2  = id_rs2_used && (id_rs2 != '0) && (cnt[id_rs2] != '0);
    assign waw_full = id_rd_we && (id_rd != '0) && (cnt[id_rd] == CMAX);
    assign id_stall = id_valid && (hazard1 || hazard2 || waw_full);
    assign issue    = id_valid && !id_stall && id_rd_we && (id_rd != '0);

    // On a tie the source that did not win last time gets the port.
    assign grant_alu = alu_valid && (!mem_valid || last_mem);
    assign grant_mem = mem_valid && (!alu_valid || !last_mem);
    assign grant     = grant_alu || grant_mem;
    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;
    assign g_rd      = grant_mem ? mem_rd : alu_rd;
    assign g_data    = grant_mem ? mem_data : alu_data;

    // cnt[0] never increments, so a grant to x0 never decrements it either.
    assign underflow = grant && (g_rd != '0) && (cnt[g_rd] == '0);

    for (genvar r = 0; r < NREG; r++) begin : g_cnt
        assign inc[r] = issue && (id_rd == RADDR'(r));
        assign dec[r] = grant && (g_rd == RADDR'(r)) && (cnt[r] != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (inc[r] && !dec[r])
                    cnt[r] <= cnt[r] + CNTW'(1);
                else if (dec[r] && !inc[r])
                    cnt[r] <= cnt[r] - CNTW'(1);
            end
        end
    end

    // reg_write pulses for one cycle per grant; data_write keeps the last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write     <= '0;
            data_write    <= '0;
            err_underflow <= 1'b0;
            last_mem      <= 1'b1;
        end else begin
            if (grant) begin
                reg_write  <= g_rd;
                data_write <= g_data;
                last_mem   <= grant_mem;
            end else begin
                reg_write  <= '0;
            end
            if (underflow)
                err_underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_id_wb_sched.sv
// Bench for id_wb_sched: directed vector table, reset corners and a randomized
// run checked against a per-register pending-count model.
module tb_id_wb_sched;
    localparam int XLEN = 32, RADDR = 5, CNTW = 2, CMAX = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid, id_rs1_used, id_rs2_used, id_rd_we;
    logic [RADDR-1:0] id_rs1, id_rs2, id_rd;
    logic             id_stall;
    logic             alu_valid, alu_ready, mem_valid, mem_ready;
    logic [RADDR-1:0] alu_rd, mem_rd, reg_write;
    logic [XLEN-1:0]  alu_data, mem_data, data_write;
    logic             err_underflow;

    always #5 clk = ~clk;

    id_wb_sched #(.XLEN(XLEN), .RADDR(RADDR), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_stall(id_stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .reg_write(reg_write), .data_write(data_write), .err_underflow(err_underflow)
    );

    int checks = 0, failures = 0;

    // Reference state: how many writebacks are owed to each register.
    int          mcnt[32];
    int          m_rw, m_err, m_last_mem;
    logic [31:0] m_dw;
    int          e_stall, e_ga, e_gm, e_issue;
    logic        s_stall, s_ar, s_mr;

    typedef struct {
        logic idv; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
        logic [4:0] rd; logic we;
        logic av; logic [4:0] ard; logic [31:0] ad;
        logic mv; logic [4:0] mrd; logic [31:0] md;
        logic es; logic ear; logic emr; logic [4:0] erw;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (mcnt[i]) mcnt[i] = 0;
        m_rw = 0; m_dw = '0; m_err = 0; m_last_mem = 1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = '0; id_rd_we = 0;
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        mem_valid = 0; mem_rd = '0; mem_data = '0;
    endtask

    task automatic predict();
        int h1, h2, wf;
        h1 = int'(id_rs1_used && id_rs1 != 0 && mcnt[id_rs1] != 0);
        h2 = int'(id_rs2_used && id_rs2 != 0 && mcnt[id_rs2] != 0);
        wf = int'(id_rd_we && id_rd != 0 && mcnt[id_rd] == CMAX);
        e_stall = int'(id_valid && (h1 != 0 || h2 != 0 || wf != 0));
        e_issue = int'(id_valid && e_stall == 0 && id_rd_we && id_rd != 0);
        if (alu_valid && mem_valid) begin
            e_ga = m_last_mem; e_gm = 1 - m_last_mem;
        end else begin
            e_ga = int'(alu_valid); e_gm = int'(mem_valid);
        end
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model at
    // the edge, then check the registered outputs just after it.
    task automatic cycle();
        int rd;
        logic [31:0] data;
        @(negedge clk);
        predict();
        s_stall = id_stall; s_ar = alu_ready; s_mr = mem_ready;
        chk("id_stall", id_stall, e_stall);
        chk("alu_ready", alu_ready, e_ga);
        chk("mem_ready", mem_ready, e_gm);
        @(posedge clk);
        if (e_ga != 0 || e_gm != 0) begin
            rd   = (e_gm != 0) ? int'(mem_rd) : int'(alu_rd);
            data = (e_gm != 0) ? mem_data : alu_data;
            if (rd != 0) begin
                if (mcnt[rd] == 0) m_err = 1;
                else mcnt[rd]--;
            end
            m_rw = rd; m_dw = data; m_last_mem = e_gm;
        end else begin
            m_rw = 0;
        end
        if (e_issue != 0) mcnt[id_rd]++;
        #1;
        chk("reg_write", reg_write, m_rw);
        chk("data_write", data_write, m_dw);
        chk("err_underflow", err_underflow, m_err);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        #2;
        chk("rst_reg_write", reg_write, 0);
        chk("rst_err", err_underflow, 0);
        chk("rst_stall", id_stall, 0);
        model_reset();
        rst = 0;
    endtask

    function automatic vec_t mk(input logic idv, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                input logic we, input logic av, input logic [4:0] ard,
                                input logic [31:0] ad, input logic mv, input logic [4:0] mrd,
                                input logic [31:0] md, input logic es, input logic ear,
                                input logic emr, input logic [4:0] erw);
        vec_t v;
        v.idv = idv; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd; v.we = we;
        v.av = av; v.ard = ard; v.ad = ad; v.mv = mv; v.mrd = mrd; v.md = md;
        v.es = es; v.ear = ear; v.emr = emr; v.erw = erw;
        return v;
    endfunction

    initial begin
        logic        a_busy, m_busy;
        int          outq[$];
        int          k;

        // Reset with an ALU writeback already waiting.
        idle_inputs();
        rst = 1;
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h5555_0005;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_reg_write", reg_write, 0);
        chk("reset_data_write", data_write, 0);
        chk("reset_err", err_underflow, 0);
        model_reset();
        rst = 0;
        cycle();
        chk("post_reset_rw5", reg_write, 5);
        chk("post_reset_err_set", err_underflow, 1);
        @(posedge clk); #1;
        chk("err_sticky", err_underflow, 1);
        do_reset();

        //         idv rs1 u1 rs2 u2 rd we  av ard ad            mv mrd md         es ar mr rw
        vecs.push_back(mk(1, 0, 0, 0, 0, 4, 1,  0, 0, 0,            0, 0, 0,        0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 6, 1,  0, 0, 0,            0, 0, 0,        0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 8, 1,  0, 0, 0,            0, 0, 0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 4, 32'h44,       1, 6, 32'h66,   0, 1, 0, 4));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 8, 32'h88,       1, 6, 32'h66,   0, 0, 1, 6));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 8, 32'h88,       0, 0, 0,        0, 1, 0, 8));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3, 1,  0, 0, 0,            0, 0, 0,        0, 0, 0, 0));
        vecs.push_back(mk(1, 3, 1, 0, 0,10, 1,  0, 0, 0,            0, 0, 0,        1, 0, 0, 0));
        vecs.push_back(mk(1, 3, 1, 0, 0,10, 1,  1, 3, 32'hDEADBEEF, 0, 0, 0,        1, 1, 0, 3));
        vecs.push_back(mk(1, 3, 1, 0, 0,10, 1,  0, 0, 0,            0, 0, 0,        0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1,  0, 0, 0,            0, 0, 0,        0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1,  0, 0, 0,            0, 0, 0,        0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1,  0, 0, 0,            0, 0, 0,        0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1,  0, 0, 0,            0, 0, 0,        1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1,  0, 0, 0,            1, 7, 32'h77,   1, 0, 1, 7));
        vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1,  0, 0, 0,            0, 0, 0,        0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 9, 1,  0, 0, 0,            0, 0, 0,        0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 9, 1,  1, 9, 32'h99,       0, 0, 0,        0, 1, 0, 9));
        vecs.push_back(mk(1, 0, 0, 9, 1, 0, 0,  0, 0, 0,            0, 0, 0,        1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1,  0, 0, 0,            0, 0, 0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 32'h1234,     0, 0, 0,        0, 1, 0, 0));
        vecs.push_back(mk(0,10, 1, 0, 0, 0, 0,  0, 0, 0,            0, 0, 0,        0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            id_valid = vecs[i].idv; id_rs1 = vecs[i].rs1; id_rs1_used = vecs[i].u1;
            id_rs2 = vecs[i].rs2; id_rs2_used = vecs[i].u2;
            id_rd = vecs[i].rd; id_rd_we = vecs[i].we;
            alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].ad;
            mem_valid = vecs[i].mv; mem_rd = vecs[i].mrd; mem_data = vecs[i].md;
            cycle();
            chk($sformatf("vec%0d_stall", i), s_stall, vecs[i].es);
            chk($sformatf("vec%0d_alu_ready", i), s_ar, vecs[i].ear);
            chk($sformatf("vec%0d_mem_ready", i), s_mr, vecs[i].emr);
            chk($sformatf("vec%0d_reg_write", i), reg_write, vecs[i].erw);
        end
        chk("x0_data_write", data_write, 32'h1234);
        chk("no_err_after_vecs", err_underflow, 0);

        // Randomized traffic: writebacks are only ever produced for issued rds.
        do_reset();
        a_busy = 0; m_busy = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                do_reset();
                a_busy = 0; m_busy = 0; outq.delete();
            end
            if (!a_busy && $urandom_range(0, 2) != 0) begin
                if (outq.size() > 0) begin
                    k = $urandom_range(0, outq.size() - 1);
                    alu_rd = 5'(outq[k]); outq.delete(k); a_busy = 1;
                end else if ($urandom_range(0, 9) == 0) begin
                    alu_rd = '0; a_busy = 1;
                end
                alu_data = $urandom;
            end
            if (!m_busy && $urandom_range(0, 2) != 0) begin
                if (outq.size() > 0) begin
                    k = $urandom_range(0, outq.size() - 1);
                    mem_rd = 5'(outq[k]); outq.delete(k); m_busy = 1;
                end else if ($urandom_range(0, 9) == 0) begin
                    mem_rd = '0; m_busy = 1;
                end
                mem_data = $urandom;
            end
            alu_valid = a_busy; mem_valid = m_busy;
            id_valid    = ($urandom_range(0, 9) < 7);
            id_rs1      = 5'($urandom_range(0, 15));
            id_rs2      = 5'($urandom_range(0, 15));
            id_rs1_used = 1'($urandom_range(0, 1));
            id_rs2_used = 1'($urandom_range(0, 1));
            id_rd       = 5'($urandom_range(0, 15));
            id_rd_we    = ($urandom_range(0, 3) != 0);
            cycle();
            if (e_ga != 0) a_busy = 0;
            if (e_gm != 0) m_busy = 0;
            if (e_issue != 0) outq.push_back(int'(id_rd));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
